// File: rtl/dcache_ctrl_if.sv
// Memory-side request/acknowledge bus of the data cache.
// master: cache controller (drives mem_req/mem_we/mem_addr/mem_wdata).
// slave : memory (drives mem_rdata and the one-cycle mem_ack pulse).
interface dcache_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   rd_en, wr_en      : load / store request from the MEM stage
//   addr, wr_data     : byte address (bits [1:0] ignored) and store data
//   rd_data           : load data, valid when rd_en=1 and dc_stall=0
//   dc_stall          : combinational pipeline freeze
//   mem               : registered memory request bus (refills and write-through)
module dcache_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINES      = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              dc_stall,
    dcache_ctrl_if.master     mem
);

    localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned WA_W   = ADDR_W - 2;
    localparam int unsigned TAG_W  = WA_W - IDX_W - OFF_W;
    localparam int unsigned LINE_W = WA_W - OFF_W;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

    // Arrays: tag/data keep their contents across reset, valid does not
    logic [DATA_W-1:0] data_arr_q [LINES][LINE_WORDS];
    logic [TAG_W-1:0]  tag_arr_q  [LINES];
    logic [LINES-1:0]  valid_q, valid_d;

    state_t            state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [WA_W-1:0]   lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // Array write port, computed by the FSM
    logic              data_wr_en;
    logic [IDX_W-1:0]  data_wr_idx;
    logic [OFF_W-1:0]  data_wr_off;
    logic [DATA_W-1:0] data_wr_val;
    logic              tag_wr_en;

    // Live request address fields
    logic [WA_W-1:0]   cur_wa;
    logic [OFF_W-1:0]  cur_off;
    logic [IDX_W-1:0]  cur_idx;
    logic [TAG_W-1:0]  cur_tag;
    logic              cur_hit;

    // Latched request address fields
    logic [OFF_W-1:0]  lat_off;
    logic [IDX_W-1:0]  lat_idx;
    logic [TAG_W-1:0]  lat_tag;
    logic [LINE_W-1:0] lat_line;
    logic              lat_hit;
    logic [OFF_W-1:0]  cnt_inc;
    logic              ack_v;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^addr[1:0];

    assign cur_wa  = addr[ADDR_W-1:2];
    assign cur_off = cur_wa[0 +: OFF_W];
    assign cur_idx = cur_wa[OFF_W +: IDX_W];
    assign cur_tag = cur_wa[WA_W-1 -: TAG_W];
    assign cur_hit = valid_q[cur_idx] && (tag_arr_q[cur_idx] == cur_tag);

    assign lat_off  = lat_addr_q[0 +: OFF_W];
    assign lat_idx  = lat_addr_q[OFF_W +: IDX_W];
    assign lat_tag  = lat_addr_q[WA_W-1 -: TAG_W];
    assign lat_line = lat_addr_q[WA_W-1 -: LINE_W];
    assign lat_hit  = valid_q[lat_idx] && (tag_arr_q[lat_idx] == lat_tag);

    assign cnt_inc = cnt_q + OFF_W'(1);
    // A stray ack while no request is outstanding is ignored
    assign ack_v   = mem.mem_ack && mem_req_q;

    assign rd_data = data_arr_q[cur_idx][cur_off];

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    // Next-state, memory request and stall logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        valid_d     = valid_q;
        data_wr_en  = 1'b0;
        data_wr_idx = lat_idx;
        data_wr_off = cnt_q;
        data_wr_val = mem.mem_rdata;
        tag_wr_en   = 1'b0;
        dc_stall    = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    dc_stall    = 1'b1;
                    lat_addr_d  = cur_wa;
                    lat_wdata_d = wr_data;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {cur_wa, 2'b00};
                    mem_wdata_d = wr_data;
                    state_d     = WRITE;
                end else if (rd_en && !cur_hit) begin
                    dc_stall   = 1'b1;
                    lat_addr_d = cur_wa;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {cur_wa[WA_W-1 -: LINE_W], OFF_W'(0), 2'b00};
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                dc_stall = 1'b1;
                if (ack_v) begin
                    data_wr_en = 1'b1;
                    cnt_d      = cnt_inc;
                    mem_addr_d = {lat_line, cnt_inc, 2'b00};
                    if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
                        tag_wr_en        = 1'b1;
                        valid_d[lat_idx] = 1'b1;
                        mem_req_d        = 1'b0;
                        cnt_d            = '0;
                        state_d          = IDLE;
                    end
                end
            end
            WRITE: begin
                dc_stall = 1'b1;
                if (ack_v) begin
                    // Write-through; only update the cache if the line is present
                    if (lat_hit) begin
                        data_wr_en  = 1'b1;
                        data_wr_off = lat_off;
                        data_wr_val = lat_wdata_q;
                    end
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = WDONE;
                end
            end
            WDONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset) begin
            dc_stall = 1'b0;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
        end
    end

    // Tag and data array write ports (not cleared by reset)
    always_ff @(posedge clk) begin
        if (!reset && data_wr_en) begin
            data_arr_q[data_wr_idx][data_wr_off] <= data_wr_val;
        end
        if (!reset && tag_wr_en) begin
            tag_arr_q[lat_idx] <= lat_tag;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: memory model returns (word address * 3)
// after a configurable number of wait cycles.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        dc_stall;

    int checks = 0;
    int errors = 0;

    int          ack_delay = 0;
    logic        spurious_ack = 1'b0;
    int          wait_cnt = 0;
    int          unstable = 0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;

    logic [31:0] txn_addr[$];
    logic        txn_we[$];
    logic [31:0] txn_wdata[$];

    dcache_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    dcache_ctrl #(
        .ADDR_W(32), .DATA_W(32), .LINES(16), .LINE_WORDS(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .dc_stall (dc_stall),
        .mem      (mem_if)
    );

    always #5 clk = ~clk;

    assign mem_if.mem_ack   = (mem_if.mem_req && (wait_cnt == ack_delay)) || spurious_ack;
    assign mem_if.mem_rdata = (mem_if.mem_addr >> 2) * 32'd3;

    // Memory wait counter, transaction log and address-stability monitor
    always @(posedge clk) begin
        if (!mem_if.mem_req || mem_if.mem_ack) wait_cnt <= 0;
        else                                   wait_cnt <= wait_cnt + 1;
        if (mem_if.mem_req && mem_if.mem_ack) begin
            txn_addr.push_back(mem_if.mem_addr);
            txn_we.push_back(mem_if.mem_we);
            txn_wdata.push_back(mem_if.mem_wdata);
        end
        if (mem_if.mem_req && prev_req && !prev_ack && (mem_if.mem_addr !== prev_addr))
            unstable <= unstable + 1;
        prev_req  <= mem_if.mem_req;
        prev_ack  <= mem_if.mem_ack;
        prev_addr <= mem_if.mem_addr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] log_addr(input int i);
        return (txn_addr.size() > i) ? txn_addr[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic log_we(input int i);
        return (txn_we.size() > i) ? txn_we[i] : 1'bx;
    endfunction

    // One access: drive at a negedge, count stall cycles, sample the
    // completing cycle, then release the request before the next edge.
    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output int stalls, output logic [31:0] data);
        @(negedge clk);
        txn_addr.delete();
        txn_we.delete();
        txn_wdata.delete();
        rd_en   = !we;
        wr_en   = we;
        addr    = a;
        wr_data = d;
        #1;
        stalls = 0;
        while (dc_stall && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        data  = rd_data;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        int          st;
        logic [31:0] rd;

        reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_stall", 32'(dc_stall), 32'd0);
        check("reset_mem_req", 32'(mem_if.mem_req), 32'd0);
        check("reset_mem_we", 32'(mem_if.mem_we), 32'd0);
        check("reset_mem_addr", mem_if.mem_addr, 32'd0);
        check("reset_mem_wdata", mem_if.mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Cold load miss and refill
        access(1'b0, 32'h100, '0, st, rd);
        check("miss_stalls", 32'(st), 32'd5);
        check("miss_rd_data", rd, 32'hC0);
        check("miss_txn_count", 32'(txn_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("miss_addr%0d", i), log_addr(i), 32'h100 + 32'(4 * i));
        check("miss_we", 32'(log_we(0)), 32'd0);

        // Hit in the refilled line
        access(1'b0, 32'h108, '0, st, rd);
        check("hit_stalls", 32'(st), 32'd0);
        check("hit_rd_data", rd, 32'hC6);
        check("hit_txn_count", 32'(txn_addr.size()), 32'd0);

        // Store hit: write-through and cache update
        access(1'b1, 32'h104, 32'hDEADBEEF, st, rd);
        check("st_stalls", 32'(st), 32'd2);
        check("st_txn_count", 32'(txn_addr.size()), 32'd1);
        check("st_we", 32'(log_we(0)), 32'd1);
        check("st_addr", log_addr(0), 32'h104);
        check("st_wdata", (txn_wdata.size() > 0) ? txn_wdata[0] : 32'hFFFF_FFFF, 32'hDEADBEEF);
        access(1'b0, 32'h104, '0, st, rd);
        check("st_hit_stalls", 32'(st), 32'd0);
        check("st_hit_data", rd, 32'hDEADBEEF);

        // Store miss: no allocate
        access(1'b1, 32'h2000, 32'h12345678, st, rd);
        check("stm_stalls", 32'(st), 32'd2);
        check("stm_addr", log_addr(0), 32'h2000);
        check("stm_we", 32'(log_we(0)), 32'd1);
        access(1'b0, 32'h2000, '0, st, rd);
        check("stm_ld_stalls", 32'(st), 32'd5);
        check("stm_ld_first_addr", log_addr(0), 32'h2000);
        check("stm_ld_txn_count", 32'(txn_addr.size()), 32'd4);
        check("stm_ld_data", rd, 32'h1800);

        // Conflict eviction from a clean state
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        access(1'b0, 32'h100, '0, st, rd);
        check("cf0_stalls", 32'(st), 32'd5);
        check("cf0_data", rd, 32'hC0);
        access(1'b0, 32'h500, '0, st, rd);
        check("cf1_stalls", 32'(st), 32'd5);
        check("cf1_first_addr", log_addr(0), 32'h500);
        check("cf1_data", rd, 32'h3C0);
        access(1'b0, 32'h100, '0, st, rd);
        check("cf2_stalls", 32'(st), 32'd5);
        check("cf2_txn_count", 32'(txn_addr.size()), 32'd4);
        check("cf2_data", rd, 32'hC0);

        // Stray ack while idle
        @(negedge clk);
        txn_addr.delete();
        spurious_ack = 1'b1;
        @(negedge clk);
        spurious_ack = 1'b0;
        #1;
        check("stray_mem_req", 32'(mem_if.mem_req), 32'd0);
        check("stray_stall", 32'(dc_stall), 32'd0);
        check("stray_txn_count", 32'(txn_addr.size()), 32'd0);

        // Slow memory: three wait cycles per word
        ack_delay = 3;
        unstable  = 0;
        access(1'b0, 32'h300, '0, st, rd);
        ack_delay = 0;
        check("slow_stalls", 32'(st), 32'd17);
        check("slow_unstable", 32'(unstable), 32'd0);
        check("slow_txn_count", 32'(txn_addr.size()), 32'd4);
        check("slow_addr3", log_addr(3), 32'h30C);
        check("slow_data", rd, 32'h240);

        // Reset in the second refill cycle abandons the line
        @(negedge clk);
        rd_en = 1'b1; addr = 32'h700;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; rd_en = 1'b0;
        #1;
        check("rst_mid_stall", 32'(dc_stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_after_mem_req", 32'(mem_if.mem_req), 32'd0);
        check("rst_after_stall", 32'(dc_stall), 32'd0);
        spurious_ack = 1'b1;
        @(negedge clk);
        spurious_ack = 1'b0;
        access(1'b0, 32'h700, '0, st, rd);
        check("rst_reload_stalls", 32'(st), 32'd5);
        check("rst_reload_first_addr", log_addr(0), 32'h700);
        check("rst_reload_txn_count", 32'(txn_addr.size()), 32'd4);
        check("rst_reload_data", rd, 32'h540);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
